// File: rtl/ecpri_rx_msg_buffer.sv
// eCPRI receive front end: parses the 4-byte common header, stores the payload in the
// external single-port RAM over its shared bus, then plays the payload out on a valid/ready stream.
module ecpri_rx_msg_buffer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_sop,
    input  logic                  s_eop,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [7:0]            msg_type,
    output logic [15:0]           payload_len,
    output logic                  err_pulse,
    output logic [1:0]            err_code
);

    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] LP_DEPTH = 17'(DEPTH);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HDR     = 3'd1;
    localparam logic [2:0] ST_WR      = 3'd2;
    localparam logic [2:0] ST_DROP    = 3'd3;
    localparam logic [2:0] ST_RD_REQ  = 3'd4;
    localparam logic [2:0] ST_RD_CAP  = 3'd5;
    localparam logic [2:0] ST_RD_HOLD = 3'd6;

    localparam logic [1:0] ERR_REV   = 2'd0;
    localparam logic [1:0] ERR_SIZE  = 2'd1;
    localparam logic [1:0] ERR_SHORT = 2'd2;
    localparam logic [1:0] ERR_LONG  = 2'd3;

    logic [2:0]            r_state;
    logic                  r_run;
    logic [1:0]            r_hdr_idx;
    logic [3:0]            r_rev;
    logic [7:0]            r_hdr_type;
    logic [7:0]            r_size_hi;
    logic [15:0]           r_size;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         r_rd_addr;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_valid;
    logic                  r_m_last;
    logic [7:0]            r_msg_type;
    logic [15:0]           r_payload_len;
    logic                  r_err_pulse;
    logic [1:0]            r_err_code;

    logic                  w_accept;
    logic                  w_wr;
    logic                  w_rd;
    logic [CW-1:0]         w_addr;
    logic [15:0]           w_size_new;
    logic                  w_rev_ok;
    logic                  w_size_ok;
    logic                  w_last_byte;
    logic                  w_rd_last;

    // Ingress is open in states 0..3 only; r_run holds it closed until the first edge after reset.
    assign s_ready     = r_run & ~r_state[2];
    assign w_accept    = s_valid & s_ready;
    assign w_wr        = (r_state == ST_WR) & w_accept;
    assign w_rd        = (r_state == ST_RD_REQ) | (r_state == ST_RD_CAP);
    assign w_addr      = w_wr ? r_cnt : (w_rd ? r_rd_addr : '0);
    assign w_size_new  = {r_size_hi, s_data[7:0]};
    assign w_rev_ok    = (r_rev == 4'h1);
    assign w_size_ok   = (w_size_new != 16'd0) && ({1'b0, w_size_new} <= LP_DEPTH);
    assign w_last_byte = (16'(r_cnt) == (r_size - 16'd1));
    assign w_rd_last   = (16'(r_rd_addr) == (r_size - 16'd1));

    assign ram_cs   = w_wr | w_rd;
    assign ram_we   = w_wr;
    assign ram_oe   = (r_state == ST_RD_CAP);
    assign ram_addr = ADDR_WIDTH'(w_addr);
    assign ram_data = w_wr ? s_data : {DATA_WIDTH{1'bz}};

    assign m_data      = r_m_data;
    assign m_valid     = r_m_valid;
    assign m_last      = r_m_last;
    assign msg_type    = r_msg_type;
    assign payload_len = r_payload_len;
    assign err_pulse   = r_err_pulse;
    assign err_code    = r_err_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_run         <= 1'b0;
            r_hdr_idx     <= 2'd0;
            r_rev         <= 4'd0;
            r_hdr_type    <= 8'd0;
            r_size_hi     <= 8'd0;
            r_size        <= 16'd0;
            r_cnt         <= '0;
            r_rd_addr     <= '0;
            r_m_data      <= '0;
            r_m_valid     <= 1'b0;
            r_m_last      <= 1'b0;
            r_msg_type    <= 8'd0;
            r_payload_len <= 16'd0;
            r_err_pulse   <= 1'b0;
            r_err_code    <= 2'd0;
        end else begin
            r_run       <= 1'b1;
            r_err_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && s_sop) begin
                        r_rev     <= s_data[7:4];
                        r_hdr_idx <= 2'd1;
                        if (s_eop) begin
                            r_err_pulse <= 1'b1;
                            r_err_code  <= ERR_SHORT;
                        end else begin
                            r_state <= ST_HDR;
                        end
                    end
                end
                ST_HDR: begin
                    if (w_accept) begin
                        if (s_sop) begin
                            // A fresh SOP silently restarts the header at byte 0.
                            r_rev     <= s_data[7:4];
                            r_hdr_idx <= 2'd1;
                            if (s_eop) begin
                                r_err_pulse <= 1'b1;
                                r_err_code  <= ERR_SHORT;
                                r_state     <= ST_IDLE;
                            end
                        end else if (r_hdr_idx == 2'd3) begin
                            r_size <= w_size_new;
                            r_cnt  <= '0;
                            if (!w_rev_ok || !w_size_ok) begin
                                r_err_pulse <= 1'b1;
                                r_err_code  <= w_rev_ok ? ERR_SIZE : ERR_REV;
                                r_state     <= s_eop ? ST_IDLE : ST_DROP;
                            end else if (s_eop) begin
                                r_err_pulse <= 1'b1;
                                r_err_code  <= ERR_SHORT;
                                r_state     <= ST_IDLE;
                            end else begin
                                r_state <= ST_WR;
                            end
                        end else begin
                            if (r_hdr_idx == 2'd1) r_hdr_type <= s_data[7:0];
                            if (r_hdr_idx == 2'd2) r_size_hi  <= s_data[7:0];
                            r_hdr_idx <= r_hdr_idx + 2'd1;
                            if (s_eop) begin
                                r_err_pulse <= 1'b1;
                                r_err_code  <= ERR_SHORT;
                                r_state     <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_WR: begin
                    if (w_accept) begin
                        if (w_last_byte) begin
                            if (s_eop) begin
                                r_msg_type    <= r_hdr_type;
                                r_payload_len <= r_size;
                                r_rd_addr     <= '0;
                                r_state       <= ST_RD_REQ;
                            end else begin
                                r_err_pulse <= 1'b1;
                                r_err_code  <= ERR_LONG;
                                r_state     <= ST_DROP;
                            end
                        end else if (s_eop) begin
                            r_err_pulse <= 1'b1;
                            r_err_code  <= ERR_SHORT;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                ST_DROP: begin
                    if (w_accept && s_eop) r_state <= ST_IDLE;
                end
                ST_RD_REQ: r_state <= ST_RD_CAP;
                ST_RD_CAP: begin
                    // The RAM drives the word registered during RD_REQ while oe is high.
                    r_m_data  <= ram_data;
                    r_m_valid <= 1'b1;
                    r_m_last  <= w_rd_last;
                    r_state   <= ST_RD_HOLD;
                end
                ST_RD_HOLD: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        if (r_m_last) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_rd_addr <= r_rd_addr + CW'(1);
                            r_state   <= ST_RD_REQ;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ecpri_rx_msg_buffer.md
Name: ecpri_rx_msg_buffer

Overview:
Receive-side front end for the eCPRI message RAM. It takes an incoming byte stream, parses and checks the 4-byte eCPRI common header, and writes the payload into the single-port RAM through its shared tri-state data bus. It then reads the stored payload back and presents it to the downstream consumer on a valid/ready stream. It is the only master of the RAM port: it drives addr/cs/we/oe and owns bus direction.

Parameters:
ADDR_WIDTH, 16, RAM address width; must match the RAM instance.
DATA_WIDTH, 8, byte lane width; fixed at 8 for header parsing.
DEPTH, 256, RAM depth in bytes; maximum accepted payload size.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
s_data  input  8  ingress byte.
s_valid  input  1  ingress byte valid.
s_sop  input  1  first byte of message, qualified by s_valid.
s_eop  input  1  last byte of message, qualified by s_valid.
s_ready  output  1  block accepts an ingress byte this cycle.
ram_addr  output  ADDR_WIDTH  RAM address.
ram_data  inout  8  RAM bus; driven only when ram_cs&ram_we, else high-Z.
ram_cs  output  1  RAM chip select.
ram_we  output  1  RAM write enable.
ram_oe  output  1  RAM output enable.
m_data  output  8  egress payload byte.
m_valid  output  1  egress byte valid.
m_last  output  1  final payload byte, qualified by m_valid.
m_ready  input  1  downstream accepts byte.
msg_type  output  8  header byte 1 of the accepted message; held until the next accepted message.
payload_len  output  16  header payload size of the accepted message; held with msg_type.
err_pulse  output  1  one-cycle pulse when a message is dropped.
err_code  output  2  drop reason, valid with err_pulse: 0 bad revision, 1 size 0 or >DEPTH, 2 short (eop early), 3 long (no eop at last byte).

Behaviour:
- Reset (async assert, sync release): state IDLE, s_ready=0, ram_cs/we/oe=0, ram_addr=0, ram_data high-Z, m_valid=0, m_last=0, m_data=0, msg_type=0, payload_len=0, err_pulse=0, err_code=0. Reset mid-message abandons all RAM contents and the partial message.
- A byte is accepted when s_valid&s_ready.
- s_ready=1 in IDLE, HDR, WR and DROP. s_ready=0 in RD_REQ, RD_CAP and RD_HOLD; there is no double buffering.
- IDLE: an accepted byte without s_sop is discarded silently. An accepted byte with s_sop is header byte 0 -> HDR. Byte 0 bits[7:4] must equal 1 (revision); bit 0 (C) is ignored.
- HDR: accepts bytes 1..3. Byte 1 is msg type; bytes 2..3 are the payload size, big-endian. After byte 3, check revision first, then size (1 <= size <= DEPTH).
  - Pass -> WR, address counter = 0.
  - Fail -> DROP, or straight to IDLE if byte 3 carried s_eop.
  - s_eop on byte 0..2 -> short error, IDLE.
  - s_sop on a later accepted byte restarts header parsing at byte 0, with no error.
- WR: each accepted byte is written in the same cycle: ram_cs=1, ram_we=1, ram_oe=0, ram_addr=count, ram_data=s_data; count then increments.
  - Byte count==size-1 with s_eop -> commit msg_type/payload_len, then RD_REQ with rd_addr=0.
  - Byte count==size-1 without s_eop -> long error, DROP.
  - s_eop earlier -> short error, IDLE.
  - Idle cycles (s_valid=0) keep ram_cs=0.
- DROP: accepts and discards until s_eop, then IDLE. err_pulse fires once, in the cycle the error is detected.
- RD_REQ (1 cycle): ram_cs=1, we=0, oe=0, addr=rd_addr; the RAM registers mem[rd_addr] internally. -> RD_CAP.
- RD_CAP (1 cycle): ram_cs=1, we=0, oe=1, addr=rd_addr. The block samples ram_data into m_data at the clock edge. -> RD_HOLD with m_valid=1, m_last=(rd_addr==size-1).
- RD_HOLD: ram_cs=0, all RAM controls 0. m_data, m_valid and m_last are stable until m_ready.
  - On handshake with m_last=1: m_valid=0, -> IDLE.
  - Otherwise: rd_addr++, m_valid=0, -> RD_REQ.
- Playout throughput is 1 byte per 3 cycles when m_ready is held high. First m_valid is 2 cycles after the last ingress byte's accept edge.
- The block never drives ram_data except in WR write cycles, so there is no bus contention. ram_we and ram_oe are never both 1.
- Only the lower log2(DEPTH) bits of the address counters are used; ram_addr is zero-extended to ADDR_WIDTH.
- s_valid is ignored while s_ready=0; the upstream must hold its byte.

Test Plan:
- Good message: bytes 0x10,0x02,0x00,0x03,AA,BB,CC with eop on CC -> RAM writes addr0..2=AA,BB,CC; m_data AA,BB,CC with m_last on CC; msg_type=0x02, payload_len=3; no err_pulse.
- Backpressure: same message, m_ready low 5 cycles per byte -> m_data held stable, no byte lost or duplicated; s_ready=0 until the last handshake, then 1.
- Bad revision: 0x20,0x00,0x00,0x02,11,22 eop -> err_code=0 pulse after byte 3; no RAM write, no m_valid; msg_type/payload_len unchanged.
- Size bounds: size 0x0000 -> err_code=1; size 0x0101 with DEPTH=256 -> err_code=1; size 0x0100 with 256 bytes -> all 256 written and played out, m_last on addr 255.
- Short/long: size 4 with eop on 2nd payload byte -> err_code=2, IDLE. Size 2 with no eop on 2nd byte and eop on 4th -> err_code=3, bytes discarded, no playout.
- Async reset asserted mid-WR and mid-RD_HOLD -> all outputs return to reset values immediately, ram_data high-Z; the next good message is processed correctly.
